// File: rtl/conf_disp_window_sum.sv
// Horizontal sliding-window accumulator of confidence and confidence*disparity,
// feeding the confidence-weighted disparity divider. Windows restart at every row end.
module conf_disp_window_sum #(
  parameter int disp_bits = 5,
  parameter int conf_bits = 5,
  parameter int win_log2  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [disp_bits-1:0]   in_disp,
  input  logic [conf_bits-1:0]   in_conf,
  input  logic                   in_valid,
  input  logic                   in_eol,
  output logic [7:0]             out_conf,
  output logic [8+disp_bits-1:0] out_conf_disp,
  output logic                   out_valid
);

  localparam int W   = 1 << win_log2;
  localparam int PW  = conf_bits + disp_bits;
  localparam int CDW = 8 + disp_bits;
  localparam logic [win_log2:0] FILL_MAX = (win_log2 + 1)'(W);

  // A full window of maximum confidence must fit the 8-bit confidence sum.
  if (W * ((1 << conf_bits) - 1) > 255) begin : g_bad_params
    $error("conf_disp_window_sum: window of %0d pixels overflows 8-bit confidence sum", W);
  end

  function automatic logic [win_log2:0] fill_inc(input logic [win_log2:0] f);
    return (f == FILL_MAX) ? FILL_MAX : f + 1'b1;
  endfunction

  logic [conf_bits-1:0] c_p1;
  logic [PW-1:0]        prod_p1;
  logic                 vld_p1;
  logic                 eol_p1;

  logic [conf_bits-1:0] ring_c [W];
  logic [PW-1:0]        ring_p [W];
  logic [win_log2-1:0]  wr_ptr;
  logic [win_log2:0]    fill;
  logic [7:0]           acc_conf;
  logic [CDW-1:0]       acc_cd;

  logic [conf_bits-1:0] old_c;
  logic [PW-1:0]        old_p;
  logic [7:0]           nc;
  logic [CDW-1:0]       np;

  // Evicted entry only counts once the window is full; earlier ring contents are stale.
  always_comb begin
    old_c = '0;
    old_p = '0;
    if (fill == FILL_MAX) begin
      old_c = ring_c[wr_ptr];
      old_p = ring_p[wr_ptr];
    end
    nc = acc_conf + 8'(c_p1) - 8'(old_c);
    np = acc_cd + CDW'(prod_p1) - CDW'(old_p);
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      ring_c[wr_ptr] <= c_p1;
      ring_p[wr_ptr] <= prod_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_p1          <= '0;
      prod_p1       <= '0;
      vld_p1        <= 1'b0;
      eol_p1        <= 1'b0;
      wr_ptr        <= '0;
      fill          <= '0;
      acc_conf      <= '0;
      acc_cd        <= '0;
      out_conf      <= '0;
      out_conf_disp <= '0;
      out_valid     <= 1'b0;
    end else begin
      // Stage 1: capture confidence and its product with disparity.
      vld_p1 <= in_valid;
      if (in_valid) begin
        c_p1    <= in_conf;
        prod_p1 <= PW'(in_conf) * PW'(in_disp);
        eol_p1  <= in_eol;
      end

      // Stage 2: window update; a row-ending pixel still sees its own window.
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_conf      <= nc;
        out_conf_disp <= np;
        if (eol_p1) begin
          acc_conf <= '0;
          acc_cd   <= '0;
          wr_ptr   <= '0;
          fill     <= '0;
        end else begin
          acc_conf <= nc;
          acc_cd   <= np;
          wr_ptr   <= wr_ptr + 1'b1;
          fill     <= fill_inc(fill);
        end
      end
    end
  end

endmodule

// File: tb/tb_conf_disp_window_sum.sv
// Directed bench for conf_disp_window_sum: row windows, eviction, saturation of the
// window fill, bubbles, one-pixel rows and mid-row reset.
module tb_conf_disp_window_sum;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_disp;
  logic [4:0]  in_conf;
  logic        in_valid;
  logic        in_eol;
  logic [7:0]  out_conf;
  logic [12:0] out_conf_disp;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  int hold_c = 0;
  int hold_cd = 0;

  int s_c[];
  int s_d[];
  bit s_e[];
  int x_c[];
  int x_cd[];

  always #5 clk = ~clk;

  conf_disp_window_sum dut (
    .clk           (clk),
    .reset         (reset),
    .in_disp       (in_disp),
    .in_conf       (in_conf),
    .in_valid      (in_valid),
    .in_eol        (in_eol),
    .out_conf      (out_conf),
    .out_conf_disp (out_conf_disp),
    .out_valid     (out_valid)
  );

  task automatic cyc(input bit v, input int c, input int d, input bit e);
    @(negedge clk);
    in_valid = v;
    in_conf  = 5'(c);
    in_disp  = 5'(d);
    in_eol   = e;
  endtask

  task automatic chk(input string tag, input bit ev, input int ec, input int ecd);
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid got %0b expected %0b", tag, out_valid, ev);
    end
    checks++;
    assert (out_conf === 8'(ec)) else begin
      errors++;
      $error("FAIL %s out_conf got %0d expected %0d", tag, out_conf, ec);
    end
    checks++;
    assert (out_conf_disp === 13'(ecd)) else begin
      errors++;
      $error("FAIL %s out_conf_disp got %0d expected %0d", tag, out_conf_disp, ecd);
    end
  endtask

  // Sends s_* (every other cycle when bubbles is set, junk with eol=1 in gaps)
  // and expects x_* two cycles after each valid pixel, held values otherwise.
  task automatic run_stream(input string tag, input bit bubbles);
    int n, sent, got, last;
    bit h1, h2, v;
    n = s_c.size();
    sent = 0;
    got = 0;
    h1 = 1'b0;
    h2 = 1'b0;
    last = bubbles ? 2 * n + 2 : n + 2;
    for (int t = 0; t < last; t++) begin
      v = (sent < n) && (!bubbles || (t % 2 == 0));
      if (v) begin
        cyc(1'b1, s_c[sent], s_d[sent], s_e[sent]);
        sent++;
      end else begin
        cyc(1'b0, 31, 31, 1'b1);
      end
      if (h2) begin
        hold_c  = x_c[got];
        hold_cd = x_cd[got];
        got++;
      end
      chk($sformatf("%s[%0d]", tag, t), h2, hold_c, hold_cd);
      h2 = h1;
      h1 = v;
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_conf  = '0;
    in_disp  = '0;
    in_eol   = 1'b0;
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    chk("reset", 1'b0, 0, 0);
    reset = 1'b0;

    // Constant row, window fills then holds
    s_c  = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    s_d  = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    s_e  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    x_c  = '{3, 6, 9, 12, 15, 18, 21, 24, 24, 24, 24, 24};
    x_cd = '{30, 60, 90, 120, 150, 180, 210, 240, 240, 240, 240, 240};
    run_stream("const", 1'b0);

    // Row boundary: new row does not inherit previous sums
    s_c  = '{2, 2, 2, 1};
    s_d  = '{4, 4, 4, 1};
    s_e  = '{0, 0, 1, 1};
    x_c  = '{2, 4, 6, 1};
    x_cd = '{8, 16, 24, 1};
    run_stream("rowbnd", 1'b0);

    // Maximum values, no wrap
    s_c  = '{31, 31, 31, 31, 31, 31, 31, 31, 31, 31};
    s_d  = '{31, 31, 31, 31, 31, 31, 31, 31, 31, 31};
    s_e  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    x_c  = '{31, 62, 93, 124, 155, 186, 217, 248, 248, 248};
    x_cd = '{961, 1922, 2883, 3844, 4805, 5766, 6727, 7688, 7688, 7688};
    run_stream("maxval", 1'b0);

    // Eviction of the oldest pixel
    s_c  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    s_d  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    s_e  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    x_c  = '{1, 3, 6, 10, 15, 21, 28, 36, 44};
    x_cd = '{1, 3, 6, 10, 15, 21, 28, 36, 44};
    run_stream("evict", 1'b0);

    // Same constant row with a bubble after every pixel
    s_c  = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    s_d  = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    s_e  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    x_c  = '{3, 6, 9, 12, 15, 18, 21, 24, 24, 24, 24, 24};
    x_cd = '{30, 60, 90, 120, 150, 180, 210, 240, 240, 240, 240, 240};
    run_stream("bubble", 1'b1);

    // One-pixel rows
    s_c  = '{5, 7, 4};
    s_d  = '{3, 2, 6};
    s_e  = '{1, 1, 1};
    x_c  = '{5, 7, 4};
    x_cd = '{15, 14, 24};
    run_stream("onepix", 1'b0);

    // Reset in the middle of a row with pixels in flight
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3, 10, 1'b0);
      if (i >= 2) chk($sformatf("rst_pre[%0d]", i), 1'b1, 3 * (i - 1), 30 * (i - 1));
      else chk($sformatf("rst_pre[%0d]", i), 1'b0, hold_c, hold_cd);
    end
    cyc(1'b0, 0, 0, 1'b0);
    chk("rst_p4", 1'b1, 12, 120);
    reset = 1'b1;
    cyc(1'b1, 2, 7, 1'b0);
    reset = 1'b0;
    chk("rst_clr", 1'b0, 0, 0);
    cyc(1'b0, 0, 0, 1'b0);
    chk("rst_gap", 1'b0, 0, 0);
    cyc(1'b0, 0, 0, 1'b0);
    chk("rst_first", 1'b1, 2, 14);
    cyc(1'b0, 0, 0, 1'b0);
    chk("rst_hold", 1'b0, 2, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
